bac_unit: RTL and testbench
===========================

# bac_unit

Bus access controller between the multi-cycle controller/datapath and the external data memory. Accepts one load or store per request, generates word-aligned memory transactions with byte enables, and extracts and sign-extends byte loads. Reports completion, misalignment and bus timeout back to the controller. The controller holds in its memory-access state while `Busy` is high and advances on `Done`.

## Interface
- `TIMEOUT`, default 64: REQ-state cycles without `mem_ack` before the access is aborted; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears the FSM and all outputs.
- `Start` in 1: request strobe, sampled only in IDLE.
- `MemWr` in 1: 1 = store, 0 = load; sampled with `Start`.
- `BACOp` in 1: 0 = word, 1 = byte; sampled with `Start`.
- `Addr` in 32: byte address from the ALU result; sampled with `Start`.
- `WData` in 32: store data (rt); sampled with `Start`.
- `Busy` out 1: high while a transaction is outstanding (REQ).
- `Done` out 1: one-cycle completion pulse (DONE).
- `RData` out 32: load result; held until the next successful load.
- `AddrErr` out 1: valid with `Done`; word access with `Addr[1:0]` ≠ 0.
- `BusErr` out 1: valid with `Done`; timeout abort.
- `mem_req` out 1: memory request, level-held until ack or abort.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 30: word address, `Addr[31:2]`.
- `mem_be` out 4: byte lane enables, little-endian.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completion; sampled only in REQ.
- `mem_rdata` in 32: read data, valid in the `mem_ack` cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**, `Start`=1, legal access: latch `MemWr`, `BACOp`, `Addr[1:0]` and the memory outputs; go to REQ.
- **IDLE**, `Start`=1, misaligned word access: no memory request; go to DONE with `AddrErr`=1.
- **REQ**, `mem_ack`=1: go to DONE.
- **REQ**, timeout counter reaches `TIMEOUT` with no ack: drop `mem_req`; go to DONE with `BusErr`=1.
- **DONE**: always returns to IDLE after one cycle.
- Word access: `mem_be`=1111; `mem_wdata`=`WData`.
- Byte access: `mem_be` = 0001 << `Addr[1:0]`; `mem_wdata` = `WData[7:0]` replicated on all four lanes.
- Word load: `RData` = `mem_rdata`.
- Byte load: `RData` = sign-extended `mem_rdata[8*Addr[1:0] +: 8]`.
- `RData` is updated only on an acked load.
- `RData` is unchanged on stores, `AddrErr` and `BusErr`.
- Memory outputs (`mem_we`, `mem_addr`, `mem_be`, `mem_wdata`) are registered and stable for the whole REQ state; they are 0 outside REQ.
- Timeout counter is 8 bits:
  - cleared on entry to REQ;
  - increments each REQ cycle without ack;
  - abort fires when the count equals `TIMEOUT`.
- `mem_ack` and timeout in the same cycle: the ack wins; normal completion, `BusErr`=0.
- `Start` in REQ or DONE: ignored, not queued. A request is only accepted in IDLE.
- `mem_ack` in IDLE or DONE: ignored.
- `AddrErr` and `BusErr` are high only in the DONE cycle.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE; all outputs 0, including `Busy`, `Done`, `RData`, `AddrErr`, `BusErr`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`.
- Reset mid-REQ: `mem_req` falls immediately, without waiting for a clock edge. The transaction is lost and `Done` is not issued.
- `Start` sampled at edge N: `mem_req` and `Busy` are high from cycle N+1.
- `mem_ack` sampled at edge M: `Done` is high in cycle M+1 and `RData` is valid from M+1.
- Minimum latency: ack in the first REQ cycle gives `Done` 2 cycles after `Start`.
- Misaligned access: `Done` and `AddrErr` in cycle N+1; `mem_req` never rises.
- Timeout: with `TIMEOUT`=T and no ack, REQ lasts T+1 cycles; `Done` and `BusErr` follow in the next cycle.
- Back-to-back: the next `Start` is accepted at the earliest in the cycle after DONE, i.e. once back in IDLE.

## Test plan
- **Word load:** `Addr`=0x0000_0010, `MemWr`=0, `BACOp`=0; ack after 3 cycles with `mem_rdata`=0xDEAD_BEEF -> `mem_addr`=0x4, `mem_be`=1111, `mem_we`=0; `Done` one cycle with `RData`=0xDEAD_BEEF; `Busy` high for exactly 3 cycles.
- **Byte load sign extension:** `Addr`=0x13, `BACOp`=1, `mem_rdata`=0x80_12_34_56 -> `mem_be`=1000, `RData`=0xFFFF_FF80. Repeat at `Addr`=0x12 -> `RData`=0x0000_0012.
- **Byte store:** `Addr`=0x21, `WData`=0x1234_56AB, `MemWr`=1, `BACOp`=1 -> `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xABAB_ABAB; `RData` unchanged.
- **Misaligned word store:** `Addr`=0x6, `BACOp`=0 -> `mem_req` stays 0; `Done`=`AddrErr`=1 in cycle N+1.
- **Timeout:** `TIMEOUT`=4, no ack -> `mem_req` high 5 cycles then `Done`=`BusErr`=1. Ack raised on the 5th cycle instead -> `BusErr`=0, normal completion.
- **Reset mid-REQ:** `reset`=0 during REQ -> `mem_req` and `Busy` drop without a clock edge; after release, `Start` in the first cycle is accepted normally. Also check that `Start` pulsed during REQ is ignored (exactly one transaction observed).

Source files
------------

// File: rtl/bac_unit.sv
// Bus access controller: turns one load/store request into a word-aligned memory transaction with byte lanes.
// Start -> mem_req 1 cycle, mem_ack -> Done 1 cycle; holds mem_req until ack or timeout, Start ignored while busy.
module bac_unit #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic        MemWr,
   input  logic        BACOp,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] RData,
   output logic        AddrErr,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  to_cnt;
   logic        lat_wr;
   logic        lat_byte;
   logic [1:0]  lat_off;
   logic        misalign;
   logic        accept;
   logic        launch;
   logic        timed_out;
   logic        req_exit;
   logic        rd_upd;
   logic [7:0]  rd_byte;
   logic [31:0] rd_val;

   assign misalign  = !BACOp && (Addr[1:0] != 2'b00);
   assign accept    = (state == IDLE) && Start;
   assign launch    = accept && !misalign;
   // ack has priority over an expiring counter in the same cycle
   assign timed_out = (state == REQ) && !mem_ack && (to_cnt == TO_LIMIT);
   assign req_exit  = (state == REQ) && (state_nxt != REQ);
   assign rd_upd    = (state == REQ) && mem_ack && !lat_wr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = misalign ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_ack || timed_out) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= 8'd0;
      end else if (launch) begin
         to_cnt <= 8'd0;
      end else if ((state == REQ) && !mem_ack) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_wr    <= 1'b0;
         lat_byte  <= 1'b0;
         lat_off   <= 2'b00;
         mem_we    <= 1'b0;
         mem_addr  <= 30'd0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'd0;
      end else if (launch) begin
         lat_wr    <= MemWr;
         lat_byte  <= BACOp;
         lat_off   <= Addr[1:0];
         mem_we    <= MemWr;
         mem_addr  <= Addr[31:2];
         mem_be    <= BACOp ? (4'b0001 << Addr[1:0]) : 4'b1111;
         mem_wdata <= BACOp ? {4{WData[7:0]}} : WData;
      end else if (req_exit) begin
         mem_we    <= 1'b0;
         mem_addr  <= 30'd0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'd0;
      end
   end

   always_comb begin
      rd_byte = mem_rdata[{lat_off, 3'b000} +: 8];
      rd_val  = lat_byte ? {{24{rd_byte[7]}}, rd_byte} : mem_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RData <= 32'd0;
      end else if (rd_upd) begin
         RData <= rd_val;
      end
   end

   // status flags are rebuilt every cycle so they only live in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Busy    <= 1'b0;
         mem_req <= 1'b0;
         Done    <= 1'b0;
         AddrErr <= 1'b0;
         BusErr  <= 1'b0;
      end else begin
         Busy    <= (state_nxt == REQ);
         mem_req <= (state_nxt == REQ);
         Done    <= (state_nxt == DONE);
         AddrErr <= accept && misalign;
         BusErr  <= timed_out;
      end
   end

endmodule

// File: tb/tb_bac_unit.sv
// Randomized and directed bench for bac_unit against a transaction-level reference model.
module tb_bac_unit;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic        MemWr = 1'b0;
   logic        BACOp = 1'b0;
   logic [31:0] Addr = 32'd0;
   logic [31:0] WData = 32'd0;
   logic        Busy, Done, AddrErr, BusErr, mem_req, mem_we;
   logic [31:0] RData, mem_wdata;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   int          checks = 0;
   int          fails = 0;
   int          req_rises = 0;
   logic        req_q = 1'b0;
   logic [31:0] exp_rdata = 32'd0;
   int          last_busy;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;
   logic        last_we;
   logic [29:0] last_addr;
   logic [103:0] all_out;

   assign all_out = {Busy, Done, RData, AddrErr, BusErr, mem_req, mem_we, mem_addr, mem_be, mem_wdata};

   bac_unit #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MemWr(MemWr), .BACOp(BACOp),
      .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .RData(RData),
      .AddrErr(AddrErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_req && !req_q) req_rises++;
      req_q = mem_req;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_load(input logic byt, input logic [1:0] off, input logic [31:0] word);
      logic [31:0] shifted;
      logic [31:0] lane;
      if (!byt) return word;
      shifted = word >> (8 * off);
      lane = shifted & 32'd255;
      if (lane >= 32'd128) return 32'hFFFF_FF00 | lane;
      return lane;
   endfunction

   task automatic run_access(input logic wr, input logic byt, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdat,
                             input int ack_at, input logic poke);
      logic        misal;
      logic [1:0]  off;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      int          k;
      int          ebusy;
      logic        seen;
      logic        acked;
      off   = addr[1:0];
      misal = !byt && (off != 2'b00);
      ebe   = byt ? 4'(1 << off) : 4'hF;
      ewd   = byt ? {4{wdata[7:0]}} : wdata;
      Start = 1'b1; MemWr = wr; BACOp = byt; Addr = addr; WData = wdata;
      tick;
      Start = 1'b0;
      if (misal) begin
         checks++;
         if ({Done, AddrErr, BusErr, mem_req, Busy} !== 5'b11000) begin
            fails++;
            $display("FAIL misaligned_done: got %b want 11000", {Done, AddrErr, BusErr, mem_req, Busy});
         end
         checks++;
         if (RData !== exp_rdata) begin
            fails++;
            $display("FAIL misaligned_rdata: got %h want %h", RData, exp_rdata);
         end
         last_busy = 0;
         tick;
         checks++;
         if ({Done, AddrErr, BusErr, mem_req, Busy} !== 5'b00000) begin
            fails++;
            $display("FAIL misaligned_idle: got %b want 00000", {Done, AddrErr, BusErr, mem_req, Busy});
         end
         return;
      end
      k = 0; seen = 1'b0; acked = 1'b0;
      while (!seen && k < T + 8) begin
         k++;
         checks++;
         if ({mem_req, Busy, mem_we, mem_addr, mem_be, mem_wdata, Done} !== {2'b11, wr, addr[31:2], ebe, ewd, 1'b0}) begin
            fails++;
            $display("FAIL req_outputs cycle %0d: got %h want %h", k,
                     {mem_req, Busy, mem_we, mem_addr, mem_be, mem_wdata, Done},
                     {2'b11, wr, addr[31:2], ebe, ewd, 1'b0});
         end
         if (k == 1) begin
            last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we; last_addr = mem_addr;
         end
         if (poke && k == 1) begin
            Start = 1'b1; Addr = $urandom; MemWr = ~wr;
         end
         if (k == ack_at) begin
            mem_ack = 1'b1; mem_rdata = rdat; acked = 1'b1;
         end
         tick;
         Start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
         seen = (Done === 1'b1);
      end
      last_busy = k;
      ebusy = acked ? ack_at : T + 1;
      checks++;
      if (!seen || k != ebusy) begin
         fails++;
         $display("FAIL busy_cycles: got %0d (done seen %0d) want %0d", k, seen, ebusy);
      end
      if (acked && !wr) exp_rdata = model_load(byt, off, rdat);
      checks++;
      if ({Done, Busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, AddrErr, BusErr} !==
          {1'b1, 3'b000, 30'd0, 4'd0, 32'd0, 1'b0, !acked}) begin
         fails++;
         $display("FAIL done_cycle: got %h want %h",
                  {Done, Busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, AddrErr, BusErr},
                  {1'b1, 3'b000, 30'd0, 4'd0, 32'd0, 1'b0, !acked});
      end
      checks++;
      if (RData !== exp_rdata) begin
         fails++;
         $display("FAIL rdata: got %h want %h", RData, exp_rdata);
      end
      if (poke) Start = 1'b1;
      tick;
      Start = 1'b0;
      checks++;
      if ({Done, AddrErr, BusErr, mem_req, Busy} !== 5'b00000) begin
         fails++;
         $display("FAIL back_to_idle: got %b want 00000", {Done, AddrErr, BusErr, mem_req, Busy});
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (all_out !== 104'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      reset = 1'b1;
      exp_rdata = 32'd0;
      tick;
      checks++;
      if (all_out !== 104'd0) begin
         fails++;
         $display("FAIL idle_after_reset: got %h want 0", all_out);
      end
   endtask

   task automatic test_word_load;
      run_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
      checks++;
      if ({last_addr, last_be, last_we} !== {30'h4, 4'b1111, 1'b0}) begin
         fails++;
         $display("FAIL word_load_bus: got %h want %h", {last_addr, last_be, last_we}, {30'h4, 4'b1111, 1'b0});
      end
      checks++;
      if (RData !== 32'hDEAD_BEEF || last_busy != 3) begin
         fails++;
         $display("FAIL word_load_result: got %h busy %0d want deadbeef busy 3", RData, last_busy);
      end
   endtask

   task automatic test_byte_load;
      run_access(1'b0, 1'b1, 32'h13, 32'h0, 32'h8012_3456, 2, 1'b0);
      checks++;
      if (last_be !== 4'b1000 || RData !== 32'hFFFF_FF80) begin
         fails++;
         $display("FAIL byte_load_13: got be %b rdata %h want be 1000 rdata ffffff80", last_be, RData);
      end
      run_access(1'b0, 1'b1, 32'h12, 32'h0, 32'h8012_3456, 1, 1'b0);
      checks++;
      if (last_be !== 4'b0100 || RData !== 32'h0000_0012) begin
         fails++;
         $display("FAIL byte_load_12: got be %b rdata %h want be 0100 rdata 00000012", last_be, RData);
      end
   endtask

   task automatic test_byte_store;
      run_access(1'b1, 1'b1, 32'h21, 32'h1234_56AB, 32'hFFFF_FFFF, 2, 1'b0);
      checks++;
      if ({last_we, last_be, last_wdata} !== {1'b1, 4'b0010, 32'hABAB_ABAB} || RData !== 32'h0000_0012) begin
         fails++;
         $display("FAIL byte_store: got we %b be %b wdata %h rdata %h want 1 0010 abababab 00000012",
                  last_we, last_be, last_wdata, RData);
      end
   endtask

   task automatic test_misaligned;
      int base;
      base = req_rises;
      run_access(1'b1, 1'b0, 32'h6, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
      checks++;
      if (req_rises != base) begin
         fails++;
         $display("FAIL misaligned_no_req: got %0d requests want 0", req_rises - base);
      end
   endtask

   task automatic test_timeout;
      run_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h1111_2222, 0, 1'b0);
      checks++;
      if (last_busy != T + 1 || RData !== 32'h0000_0012) begin
         fails++;
         $display("FAIL timeout_abort: got busy %0d rdata %h want busy %0d rdata 00000012", last_busy, RData, T + 1);
      end
      run_access(1'b0, 1'b0, 32'h104, 32'h0, 32'h5555_AAAA, T + 1, 1'b0);
      checks++;
      if (last_busy != T + 1 || RData !== 32'h5555_AAAA) begin
         fails++;
         $display("FAIL ack_beats_timeout: got busy %0d rdata %h want busy %0d rdata 5555aaaa", last_busy, RData, T + 1);
      end
   endtask

   task automatic test_reset_mid_req;
      int base;
      Start = 1'b1; MemWr = 1'b0; BACOp = 1'b0; Addr = 32'h40;
      tick;
      Start = 1'b0;
      tick;
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({mem_req, Busy} !== 2'b00 || all_out !== 104'd0) begin
         fails++;
         $display("FAIL async_reset_drop: got req %b busy %b outs %h want all 0", mem_req, Busy, all_out);
      end
      tick;
      checks++;
      if (Done !== 1'b0 || all_out !== 104'd0) begin
         fails++;
         $display("FAIL reset_no_done: got done %b outs %h want 0", Done, all_out);
      end
      reset = 1'b1;
      exp_rdata = 32'd0;
      base = req_rises;
      run_access(1'b0, 1'b0, 32'h80, 32'h0, 32'h0BAD_CAFE, 2, 1'b1);
      checks++;
      if (req_rises - base != 1) begin
         fails++;
         $display("FAIL start_in_req_ignored: got %0d transactions want 1", req_rises - base);
      end
   endtask

   task automatic test_back_to_back;
      int base;
      base = req_rises;
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, 1'b1, 32'h200 + 32'(i), 32'h0, $urandom, 1, 1'b0);
         checks++;
         if (last_busy != 1) begin
            fails++;
            $display("FAIL min_latency %0d: got busy %0d want 1", i, last_busy);
         end
      end
      checks++;
      if (req_rises - base != 3) begin
         fails++;
         $display("FAIL back_to_back_count: got %0d want 3", req_rises - base);
      end
   endtask

   task automatic test_random;
      logic        wr, byt;
      logic [31:0] addr;
      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom % 2);
         byt  = 1'($urandom % 2);
         addr = $urandom;
         if (!byt && ($urandom % 3 != 0)) addr[1:0] = 2'b00;
         run_access(wr, byt, addr, $urandom, $urandom, $urandom_range(1, T + 2), 1'($urandom % 2));
      end
   endtask

   initial begin
      test_reset;
      test_word_load;
      test_byte_load;
      test_byte_store;
      test_misaligned;
      test_timeout;
      test_reset_mid_req;
      test_back_to_back;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
